// File: rtl/o2_state_decoder.sv
// o2_state_decoder: synchronizes and debounces the two-wire O2 sensor lines,
// classifies them into NORMAL / LEAN / RICH / INVALID, and reports committed
// state changes with dwell time, lean/rich crossing count, stuck and error flags.
module o2_state_decoder #(
  parameter int DEBOUNCE    = 16,
  parameter int CNT_W       = 24,
  parameter int STUCK_LIMIT = 15000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             o2_top,
  input  logic             o2_bottom,
  input  logic             clr,
  output logic [1:0]       state,
  output logic             change_stb,
  output logic [CNT_W-1:0] dwell,
  output logic [7:0]       xover_cnt,
  output logic             stuck,
  output logic             err
);

  localparam int               DW        = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0]    DCNT_MAX  = DW'(DEBOUNCE);
  localparam logic [CNT_W-1:0] STUCK_AT  = CNT_W'(STUCK_LIMIT);
  // Synchronizer reset pattern {top, bottom} = 01 so the idle code reads as NORMAL.
  localparam logic [1:0]       SYNC_INIT = 2'b01;

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_LEAN    = 2'd1,
    ST_RICH    = 2'd2,
    ST_INVALID = 2'd3
  } o2_state_t;

  logic [1:0] pin_raw;
  logic [1:0] sync_code;

  assign pin_raw = {o2_top, o2_bottom};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;

      // Two-flop synchronizer for one asynchronous sensor line.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          meta_reg <= SYNC_INIT[gi];
          sync_reg <= SYNC_INIT[gi];
        end else begin
          meta_reg <= pin_raw[gi];
          sync_reg <= meta_reg;
        end
      end

      assign sync_code[gi] = sync_reg;
    end
  endgenerate

  o2_state_t code_cls;

  // Map the synchronized {top, bottom} pair onto the sensor classification.
  always_comb begin
    code_cls = ST_INVALID;
    case (sync_code)
      2'b01:   code_cls = ST_NORMAL;
      2'b11:   code_cls = ST_LEAN;
      2'b00:   code_cls = ST_RICH;
      default: code_cls = ST_INVALID;
    endcase
  end

  o2_state_t     cand_reg;
  logic [DW-1:0] dcnt_reg;

  // Debounce: track the current candidate code and how long it has been stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_reg <= ST_NORMAL;
      dcnt_reg <= DCNT_MAX;
    end else if (code_cls != cand_reg) begin
      cand_reg <= code_cls;
      dcnt_reg <= DW'(1);
    end else if (dcnt_reg != DCNT_MAX) begin
      dcnt_reg <= dcnt_reg + DW'(1);
    end
  end

  o2_state_t        state_reg;
  logic             change_stb_reg;
  logic [CNT_W-1:0] dwell_reg;
  logic [CNT_W-1:0] dcnt_dwell_reg;
  logic [7:0]       xover_reg;
  logic             stuck_reg;
  logic             err_reg;

  logic             commit;
  logic             crossing;
  logic [CNT_W-1:0] dwell_inc;

  // A stable candidate that differs from the committed state becomes the new state.
  assign commit    = (dcnt_reg == DCNT_MAX) && (cand_reg != state_reg);
  assign crossing  = ((state_reg == ST_LEAN) && (cand_reg == ST_RICH)) ||
                     ((state_reg == ST_RICH) && (cand_reg == ST_LEAN));
  // Saturating dwell increment, shared by the running counter and the commit report.
  assign dwell_inc = (dcnt_dwell_reg == '1) ? dcnt_dwell_reg : dcnt_dwell_reg + CNT_W'(1);

  // Committed-state machine with its statistics; clear applies before a same-edge commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_NORMAL;
      change_stb_reg <= 1'b0;
      dwell_reg      <= '0;
      dcnt_dwell_reg <= '0;
      xover_reg      <= 8'd0;
      stuck_reg      <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      change_stb_reg <= commit;
      if (commit) begin
        state_reg      <= cand_reg;
        dwell_reg      <= dwell_inc;
        dcnt_dwell_reg <= '0;
        stuck_reg      <= 1'b0;
        xover_reg      <= (clr ? 8'd0 : xover_reg) + (crossing ? 8'd1 : 8'd0);
        err_reg        <= (clr ? 1'b0 : err_reg) | (cand_reg == ST_INVALID);
      end else begin
        dcnt_dwell_reg <= dwell_inc;
        if (dwell_inc == STUCK_AT) begin
          stuck_reg <= 1'b1;
        end
        if (clr) begin
          xover_reg <= 8'd0;
          dwell_reg <= '0;
          err_reg   <= 1'b0;
        end
      end
    end
  end

  assign state      = state_reg;
  assign change_stb = change_stb_reg;
  assign dwell      = dwell_reg;
  assign xover_cnt  = xover_reg;
  assign stuck      = stuck_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_o2_state_decoder.sv
// tb_o2_state_decoder: directed scenarios plus randomized sensor traffic, checked
// every cycle against a sample-history model of the decoder.
module tb_o2_state_decoder;

  localparam int D     = 4;
  localparam int CW    = 16;
  localparam int LIMIT = 100;
  localparam int SAT   = 65535;

  localparam logic [1:0] P_NORMAL  = 2'b01;
  localparam logic [1:0] P_LEAN    = 2'b11;
  localparam logic [1:0] P_RICH    = 2'b00;
  localparam logic [1:0] P_INVALID = 2'b10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          o2_top;
  logic          o2_bottom;
  logic          clr;
  logic [1:0]    state;
  logic          change_stb;
  logic [CW-1:0] dwell;
  logic [7:0]    xover_cnt;
  logic          stuck;
  logic          err;

  int checks = 0;
  int errors = 0;

  o2_state_decoder #(
    .DEBOUNCE   (D),
    .CNT_W      (CW),
    .STUCK_LIMIT(LIMIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .o2_top    (o2_top),
    .o2_bottom (o2_bottom),
    .clr       (clr),
    .state     (state),
    .change_stb(change_stb),
    .dwell     (dwell),
    .xover_cnt (xover_cnt),
    .stuck     (stuck),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic logic [1:0] classify(input logic [1:0] pins);
    case (pins)
      2'b01:   return 2'd0;
      2'b11:   return 2'd1;
      2'b00:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // Inputs as seen by the DUT at each rising edge.
  logic       s_rst_n = 1'b0;
  logic [1:0] s_code  = 2'b01;
  logic       s_clr   = 1'b0;

  always @(posedge clk) begin
    s_rst_n <= rst_n;
    s_code  <= {o2_top, o2_bottom};
    s_clr   <= clr;
  end

  // Reference model: commit when the sensor class sampled 3..D+2 edges ago was
  // constant for D samples and differs from the current state.
  logic [1:0] hist[$];
  logic [1:0] m_state;
  logic       m_stb;
  int         m_dwell;
  logic [7:0] m_xover;
  logic       m_stuck;
  logic       m_err;
  int         m_since;
  int         m_edge;

  initial begin : model_and_compare
    logic [1:0] c;
    logic       steady;
    logic       commit;
    forever begin
      @(negedge clk);
      if (!s_rst_n) begin
        hist.delete();
        for (int i = 0; i < D + 2; i++) hist.push_back(2'd0);
        m_state = 2'd0; m_stb = 1'b0; m_dwell = 0; m_xover = 8'd0;
        m_stuck = 1'b0; m_err = 1'b0; m_since = 0; m_edge = 0;
      end else begin
        m_edge++;
        m_since++;
        c = hist[0];
        steady = 1'b1;
        for (int i = 1; i < D; i++) if (hist[i] != c) steady = 1'b0;
        commit = steady && (c != m_state);
        if (s_clr) begin
          m_xover = 8'd0; m_dwell = 0; m_err = 1'b0;
        end
        m_stb = commit;
        if (commit) begin
          if ((m_state == 2'd1 && c == 2'd2) || (m_state == 2'd2 && c == 2'd1)) m_xover = m_xover + 8'd1;
          if (c == 2'd3) m_err = 1'b1;
          m_dwell = (m_since > SAT) ? SAT : m_since;
          m_state = c;
          m_since = 0;
          m_stuck = 1'b0;
        end else if (m_since >= LIMIT) begin
          m_stuck = 1'b1;
        end
        hist.push_back(classify(s_code));
        void'(hist.pop_front());
      end
      chk("cmp_state", state, m_state);
      chk("cmp_change_stb", change_stb, m_stb);
      chk("cmp_dwell", dwell, m_dwell);
      chk("cmp_xover_cnt", xover_cnt, m_xover);
      chk("cmp_stuck", stuck, m_stuck);
      chk("cmp_err", err, m_err);
      if (m_stb)
        $display("commit edge %0d state %0d dwell %0d xover %0d err %0d",
                 m_edge, m_state, m_dwell, m_xover, m_err);
    end
  end

  // Drive a code, expect its commit on the 7th falling edge, then hold to len cycles.
  task automatic seg(input logic [1:0] pins, input int len, input int exp_dwell);
    {o2_top, o2_bottom} = pins;
    repeat (7) @(negedge clk);
    chk("seg_stb", change_stb, 1);
    chk("seg_state", state, classify(pins));
    if (exp_dwell >= 0) chk("seg_dwell", dwell, exp_dwell);
    repeat (len - 7) @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin : stimulus
    int stbs;
    int len;
    rst_n = 1'b0;
    {o2_top, o2_bottom} = P_INVALID;
    clr = 1'b0;
    repeat (5) @(negedge clk);

    // Reset release with idle lines: nothing may commit.
    {o2_top, o2_bottom} = P_NORMAL;
    rst_n = 1'b1;
    stbs = 0;
    repeat (50) begin
      @(negedge clk);
      if (change_stb) stbs++;
    end
    chk("reset_no_stb", stbs, 0);
    chk("reset_state", state, 0);

    // Latency: commit exactly six edges after first sample.
    {o2_top, o2_bottom} = P_LEAN;
    repeat (6) @(negedge clk);
    chk("lat_stb_k5", change_stb, 0);
    chk("lat_state_k5", state, 0);
    @(negedge clk);
    chk("lat_stb_k6", change_stb, 1);
    chk("lat_state_k6", state, 1);
    @(negedge clk);
    chk("lat_stb_k7", change_stb, 0);
    repeat (4) @(negedge clk);
    seg(P_NORMAL, 12, -1);

    // Glitches: 3 cycles is filtered, 4 cycles commits LEAN then NORMAL.
    {o2_top, o2_bottom} = P_LEAN;
    repeat (3) @(negedge clk);
    {o2_top, o2_bottom} = P_NORMAL;
    repeat (12) @(negedge clk);
    chk("glitch3_state", state, 0);
    {o2_top, o2_bottom} = P_LEAN;
    repeat (4) @(negedge clk);
    {o2_top, o2_bottom} = P_NORMAL;
    repeat (3) @(negedge clk);
    chk("glitch4_lean_stb", change_stb, 1);
    chk("glitch4_lean_state", state, 1);
    repeat (4) @(negedge clk);
    chk("glitch4_norm_stb", change_stb, 1);
    chk("glitch4_norm_state", state, 0);
    chk("glitch4_dwell", dwell, 4);
    repeat (10) @(negedge clk);

    // NORMAL -> LEAN -> RICH -> NORMAL, 40 cycles each.
    pulse_clr();
    seg(P_LEAN, 40, -1);
    seg(P_RICH, 40, 40);
    seg(P_NORMAL, 40, 40);
    chk("seq_xover", xover_cnt, 1);
    chk("seq_err", err, 0);

    // Stuck timing and dwell saturation.
    seg(P_RICH, 7, 40);
    repeat (99) @(negedge clk);
    chk("stuck_a99", stuck, 0);
    @(negedge clk);
    chk("stuck_a100", stuck, 1);
    {o2_top, o2_bottom} = P_NORMAL;
    repeat (6) @(negedge clk);
    chk("stuck_hold", stuck, 1);
    @(negedge clk);
    chk("stuck_clear_stb", change_stb, 1);
    chk("stuck_clear", stuck, 0);
    repeat (66000) @(negedge clk);
    seg(P_LEAN, 12, SAT);

    // Invalid code, then clear coinciding with a LEAN->RICH commit.
    pulse_clr();
    {o2_top, o2_bottom} = P_INVALID;
    repeat (10) @(negedge clk);
    chk("inv_state", state, 3);
    chk("inv_err", err, 1);
    for (int i = 0; i < 6; i++) seg((i % 2 == 0) ? P_RICH : P_LEAN, 10, 10);
    chk("pre_clr_xover", xover_cnt, 5);
    {o2_top, o2_bottom} = P_RICH;
    repeat (6) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clrc_stb", change_stb, 1);
    chk("clrc_state", state, 2);
    chk("clrc_xover", xover_cnt, 1);
    chk("clrc_err", err, 0);
    repeat (5) @(negedge clk);

    // Crossing counter wraps 255 -> 0.
    pulse_clr();
    for (int i = 0; i < 256; i++) seg((i % 2 == 0) ? P_LEAN : P_RICH, 7, (i == 0) ? -1 : 7);
    chk("xover_wrap", xover_cnt, 0);
    seg(P_LEAN, 7, 7);
    chk("xover_after_wrap", xover_cnt, 1);

    // Reset in the middle of a debounce clears outputs immediately.
    {o2_top, o2_bottom} = P_NORMAL;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_state", state, 0);
    chk("midrst_xover", xover_cnt, 0);
    chk("midrst_dwell", dwell, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Randomized sensor traffic with occasional clears.
    repeat (150) begin
      {o2_top, o2_bottom} = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        clr = ($urandom_range(0, 19) == 0);
        @(negedge clk);
      end
      clr = 1'b0;
    end
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
